// File: rtl/block_ram_arbiter.sv
// block_ram_arbiter
//   Two-requester arbiter and access sequencer for a single-port block RAM.
//   Port A (CPU) and port B (loader/DMA) compete for the RAM; simultaneous
//   requests are resolved round-robin against the last grant. Each access
//   runs IDLE -> SETUP -> WAIT (WAIT_CYCLES cycles) -> DONE so that read data
//   is captured only once it has settled. All outputs are registered.
//
// Handshake (per port x = a|b): the requester raises x_req with stable
//   x_write/x_address/x_wdata and keeps them until x_ready pulses for one
//   cycle. Fields are latched at grant, so later changes do not affect the
//   access in flight. If x_req is still high while the arbiter is back in
//   IDLE, that counts as a new request. Dropping x_req early does not cancel
//   an access that has already been granted.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   a_/b_req, _write, _address, _wdata   request inputs
//   a_/b_rdata                 registered read data, held until the port's
//                              next read completes
//   a_/b_ready                 one-cycle completion pulse
//   busy                       high in every state except IDLE
//   ram_address, ram_data_in, ram_chip_enable, ram_write_enable  RAM drive
//   ram_data_out               RAM read data
//   dbg_state                  current FSM state (0 IDLE, 1 SETUP, 2 WAIT, 3 DONE)
module block_ram_arbiter #(
  parameter int ADDR_WIDTH  = 14,
  parameter int DATA_WIDTH  = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_write,
  input  logic [ADDR_WIDTH-1:0] a_address,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic                  b_req,
  input  logic                  b_write,
  input  logic [ADDR_WIDTH-1:0] b_address,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  a_ready,
  output logic                  b_ready,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  ram_chip_enable,
  output logic                  ram_write_enable,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] wait_cnt;
  logic       last_grant;   // 0 = A, 1 = B
  logic       cur_port;     // port owning the access in flight
  logic       cur_write;
  logic       grant_a, grant_b;

  assign dbg_state = state;

  // A wins unless only B asks, or both ask and A was served last.
  always_comb begin
    grant_a = a_req && (!b_req || last_grant);
    grant_b = b_req && !grant_a;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (a_req || b_req) state_nxt = S_SETUP;
      S_SETUP: state_nxt = S_WAIT;
      S_WAIT:  if (wait_cnt == 4'd1) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are set on the edge entering the state they belong to, so that
  // e.g. chip enable is already high during the SETUP cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt         <= '0;
      last_grant       <= 1'b1;
      cur_port         <= 1'b0;
      cur_write        <= 1'b0;
      ram_address      <= '0;
      ram_data_in      <= '0;
      ram_chip_enable  <= 1'b0;
      ram_write_enable <= 1'b0;
      a_rdata          <= '0;
      b_rdata          <= '0;
      a_ready          <= 1'b0;
      b_ready          <= 1'b0;
      busy             <= 1'b0;
    end else begin
      a_ready <= 1'b0;
      b_ready <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_a || grant_b) begin
            ram_address      <= grant_b ? b_address : a_address;
            ram_data_in      <= grant_b ? b_wdata   : a_wdata;
            cur_write        <= grant_b ? b_write   : a_write;
            ram_write_enable <= grant_b ? b_write   : a_write;
            cur_port         <= grant_b;
            last_grant       <= grant_b;
            ram_chip_enable  <= 1'b1;
            busy             <= 1'b1;
          end
        end
        S_SETUP: begin
          wait_cnt <= 4'(WAIT_CYCLES);
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          // Write strobe ends as DONE begins; CE stays up through DONE.
          if (wait_cnt == 4'd1) ram_write_enable <= 1'b0;
        end
        S_DONE: begin
          ram_chip_enable  <= 1'b0;
          ram_write_enable <= 1'b0;
          busy             <= 1'b0;
          if (cur_port) begin
            b_ready <= 1'b1;
            if (!cur_write) b_rdata <= ram_data_out;
          end else begin
            a_ready <= 1'b1;
            if (!cur_write) a_rdata <= ram_data_out;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_block_ram_arbiter.sv
module tb_block_ram_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- main DUT (WAIT_CYCLES = 2) ----------------
  logic        a_req = 0, a_write = 0, b_req = 0, b_write = 0;
  logic [13:0] a_address = 0, b_address = 0;
  logic [15:0] a_wdata = 0, b_wdata = 0;
  logic [15:0] a_rdata, b_rdata;
  logic        a_ready, b_ready, busy;
  logic [13:0] ram_address;
  logic [15:0] ram_data_in, ram_data_out;
  logic        ram_chip_enable, ram_write_enable;
  logic [1:0]  dbg_state;

  logic [15:0] mem [0:16383];

  always @(posedge clk)
    if (ram_chip_enable && ram_write_enable) mem[ram_address] <= ram_data_in;
  assign ram_data_out = mem[ram_address];

  block_ram_arbiter #(.ADDR_WIDTH(14), .DATA_WIDTH(16), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_write(a_write), .a_address(a_address), .a_wdata(a_wdata),
    .b_req(b_req), .b_write(b_write), .b_address(b_address), .b_wdata(b_wdata),
    .a_rdata(a_rdata), .b_rdata(b_rdata), .a_ready(a_ready), .b_ready(b_ready),
    .busy(busy), .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out), .ram_chip_enable(ram_chip_enable),
    .ram_write_enable(ram_write_enable), .dbg_state(dbg_state)
  );

  // ---------------- WAIT_CYCLES = 1 and 15 builds (read-only view of mem) ----
  logic        t1_req = 0, t15_req = 0;
  logic [13:0] t_address = 0;
  logic [15:0] w1_a_rdata, w1_b_rdata, w1_din, w1_dout;
  logic [15:0] w15_a_rdata, w15_b_rdata, w15_din, w15_dout;
  logic [13:0] w1_addr, w15_addr;
  logic        w1_a_ready, w1_b_ready, w1_busy, w1_ce, w1_we;
  logic        w15_a_ready, w15_b_ready, w15_busy, w15_ce, w15_we;
  logic [1:0]  w1_state, w15_state;

  assign w1_dout  = mem[w1_addr];
  assign w15_dout = mem[w15_addr];

  block_ram_arbiter #(.ADDR_WIDTH(14), .DATA_WIDTH(16), .WAIT_CYCLES(1)) dut_w1 (
    .clk(clk), .reset(reset),
    .a_req(t1_req), .a_write(1'b0), .a_address(t_address), .a_wdata(16'h0),
    .b_req(1'b0), .b_write(1'b0), .b_address(14'h0), .b_wdata(16'h0),
    .a_rdata(w1_a_rdata), .b_rdata(w1_b_rdata), .a_ready(w1_a_ready), .b_ready(w1_b_ready),
    .busy(w1_busy), .ram_address(w1_addr), .ram_data_in(w1_din),
    .ram_data_out(w1_dout), .ram_chip_enable(w1_ce),
    .ram_write_enable(w1_we), .dbg_state(w1_state)
  );

  block_ram_arbiter #(.ADDR_WIDTH(14), .DATA_WIDTH(16), .WAIT_CYCLES(15)) dut_w15 (
    .clk(clk), .reset(reset),
    .a_req(t15_req), .a_write(1'b0), .a_address(t_address), .a_wdata(16'h0),
    .b_req(1'b0), .b_write(1'b0), .b_address(14'h0), .b_wdata(16'h0),
    .a_rdata(w15_a_rdata), .b_rdata(w15_b_rdata), .a_ready(w15_a_ready), .b_ready(w15_b_ready),
    .busy(w15_busy), .ram_address(w15_addr), .ram_data_in(w15_din),
    .ram_data_out(w15_dout), .ram_chip_enable(w15_ce),
    .ram_write_enable(w15_we), .dbg_state(w15_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];   // {port, rdata} in expected completion order

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    bit          port;       // 0 = A, 1 = B
    bit          wr;
    logic [13:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;  // port's rdata after completion (unchanged on writes)
    bit          chg;        // move the address by one after grant
  } vec_t;

  vec_t vecs[8];

  // One access through the main DUT with its timing checks.
  task automatic run_access(input vec_t v);
    int n, we_cycles, busy_cycles;
    bit got, other_rdy, addr_ok;
    logic [15:0] other_before;
    n = 0; we_cycles = 0; busy_cycles = 0; got = 0; other_rdy = 0; addr_ok = 1;
    other_before = v.port ? a_rdata : b_rdata;
    if (v.port) begin
      b_write = v.wr; b_address = v.addr; b_wdata = v.wdata; b_req = 1'b1;
    end else begin
      a_write = v.wr; a_address = v.addr; a_wdata = v.wdata; a_req = 1'b1;
    end
    while (!got && n < 40) begin
      tick();
      n++;
      if (n == 1 && v.chg) begin
        if (v.port) b_address = v.addr + 14'd1;
        else        a_address = v.addr + 14'd1;
      end
      if (ram_write_enable) we_cycles++;
      if (busy) busy_cycles++;
      if (ram_chip_enable && ram_address !== v.addr) addr_ok = 0;
      if ((v.port ? a_ready : b_ready) === 1'b1) other_rdy = 1;
      if ((v.port ? b_ready : a_ready) === 1'b1) got = 1;
    end
    a_req = 1'b0;
    b_req = 1'b0;
    check({v.name, " ready seen"}, 32'(got), 32'd1);
    check({v.name, " latency"}, 32'(n - 1), 32'd4);
    check({v.name, " rdata"}, 32'(v.port ? b_rdata : a_rdata), 32'(v.exp_rdata));
    check({v.name, " other rdata"}, 32'(v.port ? a_rdata : b_rdata), 32'(other_before));
    check({v.name, " other ready"}, 32'(other_rdy), 32'd0);
    check({v.name, " we cycles"}, 32'(we_cycles), v.wr ? 32'd3 : 32'd0);
    check({v.name, " busy cycles"}, 32'(busy_cycles), 32'd4);
    check({v.name, " address stable"}, 32'(addr_ok), 32'd1);
    tick();
    check({v.name, " single pulse"}, {30'd0, a_ready, b_ready}, 32'd0);
    check({v.name, " back idle"}, 32'(dbg_state), 32'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    int k, seen, last_k;
    int lat1, lat15;
    bit first_a, first_b;

    for (int i = 0; i < 16384; i++) mem[i] = 16'h0000;
    mem[14'h0010] = 16'h1234;
    mem[14'h0001] = 16'h1111;
    mem[14'h0002] = 16'h2222;
    mem[14'h0020] = 16'hAAAA;
    mem[14'h0030] = 16'h5555;
    mem[14'h3FFF] = 16'hF00D;

    vecs[0] = '{"a_rd_0010",  1'b0, 1'b0, 14'h0010, 16'h0000, 16'h1234, 1'b0};
    vecs[1] = '{"b_wr_0123",  1'b1, 1'b1, 14'h0123, 16'hBEEF, 16'h0000, 1'b0};
    vecs[2] = '{"a_rd_0123",  1'b0, 1'b0, 14'h0123, 16'h0000, 16'hBEEF, 1'b0};
    vecs[3] = '{"b_rd_0030",  1'b1, 1'b0, 14'h0030, 16'h0000, 16'h5555, 1'b0};
    vecs[4] = '{"a_wr_0030",  1'b0, 1'b1, 14'h0030, 16'hCAFE, 16'hBEEF, 1'b0};
    vecs[5] = '{"b_rd_0030b", 1'b1, 1'b0, 14'h0030, 16'h0000, 16'hCAFE, 1'b0};
    vecs[6] = '{"a_rd_3fff",  1'b0, 1'b0, 14'h3FFF, 16'h0000, 16'hF00D, 1'b0};
    vecs[7] = '{"a_rd_chg",   1'b0, 1'b0, 14'h0001, 16'h0000, 16'h1111, 1'b1};

    // Reset state
    #2;
    check("reset outputs", {ram_address, ram_chip_enable, ram_write_enable, busy, a_ready, b_ready},
          32'd0);
    check("reset rdata", {a_rdata, b_rdata}, 32'd0);
    check("reset ram_data_in", 32'(ram_data_in), 32'd0);
    check("reset state", 32'(dbg_state), 32'd0);
    do_reset();

    foreach (vecs[i]) run_access(vecs[i]);

    // Continuous tie: A, B, A, B with one completion every 5 cycles.
    do_reset();
    a_write = 0; a_address = 14'h0020;
    b_write = 0; b_address = 14'h0030;
    exp_q.push_back({1'b0, 16'hAAAA});
    exp_q.push_back({1'b1, 16'hCAFE});
    exp_q.push_back({1'b0, 16'hAAAA});
    exp_q.push_back({1'b1, 16'hCAFE});
    a_req = 1; b_req = 1;
    k = 0; seen = 0; last_k = 0;
    while (seen < 4 && k < 60) begin
      tick();
      k++;
      if (a_ready || b_ready) begin
        logic [16:0] e;
        e = exp_q.pop_front();
        check($sformatf("tie grant %0d port", seen), {30'd0, a_ready, b_ready},
              e[16] ? 32'd1 : 32'd2);
        check($sformatf("tie grant %0d data", seen), 32'(e[16] ? b_rdata : a_rdata), 32'(e[15:0]));
        check($sformatf("tie grant %0d spacing", seen), 32'(k - last_k), (seen == 0) ? 32'd5 : 32'd5);
        last_k = k;
        seen++;
      end
    end
    a_req = 0; b_req = 0;
    check("tie completions", 32'(seen), 32'd4);
    tick();

    // Reset during WAIT of a write.
    b_write = 1; b_address = 14'h0040; b_wdata = 16'h1357; b_req = 1;
    tick();
    tick();
    check("midwrite in wait", 32'(dbg_state), 32'd2);
    check("midwrite we high", 32'(ram_write_enable), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("midwrite async outputs", {ram_address, ram_chip_enable, ram_write_enable, busy, a_ready, b_ready},
          32'd0);
    check("midwrite async rdata", {a_rdata, b_rdata}, 32'd0);
    check("midwrite async state", 32'(dbg_state), 32'd0);
    b_req = 0; b_write = 0;
    first_a = 0; first_b = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (a_ready || b_ready) first_b = 1;
    end
    check("midwrite no ready", 32'(first_b), 32'd0);
    reset = 1'b0;
    a_address = 14'h0002; b_address = 14'h0001;
    a_req = 1; b_req = 1;
    k = 0; first_a = 0; first_b = 0;
    while (!(first_a || first_b) && k < 40) begin
      tick();
      k++;
      first_a = a_ready;
      first_b = b_ready;
    end
    a_req = 0; b_req = 0;
    check("post-reset tie winner", {30'd0, first_a, first_b}, 32'd2);
    check("post-reset tie data", 32'(a_rdata), 32'h2222);
    tick();

    // WAIT_CYCLES = 1 and 15 builds.
    t_address = 14'h0020;
    t1_req = 1; t15_req = 1;
    k = 0; lat1 = -1; lat15 = -1;
    while ((lat1 < 0 || lat15 < 0) && k < 60) begin
      tick();
      k++;
      if (w1_a_ready && lat1 < 0)   begin lat1 = k - 1;  t1_req = 0;  end
      if (w15_a_ready && lat15 < 0) begin lat15 = k - 1; t15_req = 0; end
    end
    t1_req = 0; t15_req = 0;
    check("w1 latency", 32'(lat1), 32'd3);
    check("w1 rdata", 32'(w1_a_rdata), 32'hAAAA);
    check("w15 latency", 32'(lat15), 32'd17);
    check("w15 rdata", 32'(w15_a_rdata), 32'hAAAA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/block_ram_arbiter.md
# block_ram_arbiter

Two-requester arbiter and access sequencer for the 16-bit `block_ram` instance. It takes read/write requests from a primary port (CPU) and a secondary port (loader/DMA), grants the RAM round-robin on ties, and drives the RAM's address, data, chip-enable and write-enable through a fixed multi-cycle sequence so read data is captured only after it is stable. It sits between the CPU/loader and `block_ram` and is the only driver of the RAM control pins.

## Interface
- `ADDR_WIDTH`, 14, address width of both ports and the RAM.
- `DATA_WIDTH`, 16, data width of both ports and the RAM.
- `WAIT_CYCLES`, 2, cycles held in WAIT before capture; legal range 1..15.

- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `a_req`, `b_req`  in  1  request, held high with stable fields until `x_ready`.
- `a_write`, `b_write`  in  1  1 = write, 0 = read.
- `a_address`, `b_address`  in  ADDR_WIDTH  word address.
- `a_wdata`, `b_wdata`  in  DATA_WIDTH  write data.
- `a_rdata`, `b_rdata`  out  DATA_WIDTH  read data, registered, valid when `x_ready` = 1 and held until that port's next read completes.
- `a_ready`, `b_ready`  out  1  one-cycle completion pulse, for reads and writes.
- `busy`  out  1  high in every state except IDLE.
- `ram_address`  out  ADDR_WIDTH  to `block_ram.address`.
- `ram_data_in`  out  DATA_WIDTH  to `block_ram.data_in`.
- `ram_data_out`  in  DATA_WIDTH  from `block_ram.data_out`.
- `ram_chip_enable`, `ram_write_enable`  out  1  to `block_ram`.

## Operation
- States: IDLE, SETUP, WAIT, DONE. All outputs come from registers.
- IDLE: sample `a_req`/`b_req`.
  - Neither set: stay in IDLE.
  - Only one set: grant that port.
  - Both set: grant the port that is not `last_grant`.
  - On a grant: latch the port's address, wdata and write into `ram_*`, record `last_grant`, then go to SETUP.
- SETUP: `ram_chip_enable` = 1; `ram_write_enable` = latched write; load `wait_cnt` = WAIT_CYCLES; go to WAIT.
- WAIT: `ram_chip_enable` = 1; `ram_write_enable` unchanged. Decrement `wait_cnt` each cycle and go to DONE when it reaches 1, so WAIT lasts exactly WAIT_CYCLES cycles.
- DONE: `ram_chip_enable` = 1; `ram_write_enable` = 0. Pulse the granted port's `x_ready`. On a read, register `ram_data_out` into that port's `x_rdata`; on a write, `x_rdata` is unchanged. Go to IDLE.
- Request fields are latched at grant. Requester changes after grant have no effect on the access in flight.
- A requester drops `x_req` on the cycle after `x_ready`. If `x_req` is still high in IDLE, it is a new request.
- If `x_req` falls before `x_ready`, the access still completes and `x_ready` still pulses.
- There is no pipelining; at most one access is in flight.
- `ram_address` and `ram_data_in` hold their last value through IDLE. `ram_chip_enable` and `ram_write_enable` are 0 in IDLE.

## Timing
- Reset (asynchronous, any state, including mid-write):
  - state = IDLE, `wait_cnt` = 0.
  - `last_grant` = B, so A wins the first tie.
  - All outputs = 0: `ram_address`, `ram_data_in`, `ram_chip_enable`, `ram_write_enable`, `a_rdata`, `b_rdata`, `a_ready`, `b_ready`, `busy`.
  - An interrupted write can leave the target RAM word undefined. No `ready` is produced for it.
- Latency: with `x_req` sampled high in IDLE at edge T, `x_ready` is high during the cycle after edge T+2+WAIT_CYCLES. For WAIT_CYCLES = 2, `ready` is high 4 cycles after the request edge.
- Throughput: one access per WAIT_CYCLES+3 cycles (5 at default). Under a continuous tie, grants strictly alternate A, B, A, B.
- `ram_write_enable` is high for exactly 1+WAIT_CYCLES cycles per write and never in DONE or IDLE.
- `busy` rises on the edge that leaves IDLE and falls on the edge that enters IDLE.

## Test plan
- Reset then A read: preload RAM[0x0010] = 16'h1234. Assert `a_req`, `a_write` = 0, `a_address` = 14'h0010. Expect `a_ready` once, 4 cycles after the request edge, with `a_rdata` = 16'h1234; `b_ready` stays 0.
- B write then A read-back: B writes 16'hBEEF to 14'h0123. Check `ram_write_enable` is high for exactly 3 cycles and `b_ready` pulses once. A then reads 14'h0123 and gets 16'hBEEF; `b_rdata` is unchanged.
- Tie arbitration: hold `a_req` and `b_req` continuously after reset. Grants go A, B, A, B, one `ready` every 5 cycles, and each port receives its own address's data.
- Field change after grant: A requests a read of 14'h0001, then changes `a_address` to 14'h0002 in SETUP. RAM sees 14'h0001 throughout, and `a_rdata` = RAM[0x0001].
- Reset mid-write: assert `reset` during WAIT of a write. All outputs go to 0 immediately, state returns to IDLE, no `ready` pulses, and the first tie after release grants A.
- WAIT_CYCLES = 1 and 15: `ready` arrives at 3 and 17 cycles after the request edge respectively, and read data is correct in both builds.
